spell_mem_param: RTL and testbench

SPELL_MEM_PARAM -- requirements
Module: spell_mem_param

---
 rtl/spell_mem_pkg.sv | 25 ++
 rtl/spell_mem_bank.sv | 43 ++++
 rtl/spell_mem_param.sv | 131 +++++++++++++
 tb/tb_spell_mem_param.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spell_mem_pkg.sv
// Shared constants and helpers for the spell memory block: memory-type
// encodings, default geometry/latency and the address range check.
package spell_mem_pkg;

  localparam logic MEM_TYPE_CODE = 1'b0;
  localparam logic MEM_TYPE_DATA = 1'b1;

  localparam int DEFAULT_CODE_DEPTH = 32;
  localparam int DEFAULT_DATA_DEPTH = 8;
  localparam int DEFAULT_LATENCY    = 4;

  // Latency counter holds LATENCY-1, and LATENCY never exceeds 16.
  localparam int CNT_W = 4;

  // Unsigned 9-bit compare so a depth of 256 admits every 8-bit address.
  function automatic logic addr_in_range(input logic [7:0] addr, input logic [8:0] depth);
    return ({1'b0, addr} < depth);
  endfunction

  // Index width for a bank; a one-entry bank still gets a 1-bit index.
  function automatic int bank_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spell_mem_bank.sv
// One 8-bit memory array with synchronous whole-array clear, write port and
// registered read data. The array is rounded up to a power of two so the
// index is exactly IDX_W bits; the caller never addresses past DEPTH.
module spell_mem_bank
  import spell_mem_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DATA_DEPTH,
  localparam int IDX_W = bank_idx_w(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data
);

  localparam int SLOTS = 1 << IDX_W;

  logic [7:0] mem_r [SLOTS];
  logic [7:0] rd_data_r;

  // Clear wipes every entry and the read register; otherwise write and/or read.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem_r[i] <= 8'h00;
      end
      rd_data_r <= 8'h00;
    end else begin
      if (wr_en) begin
        mem_r[addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data_r <= mem_r[addr];
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/spell_mem_param.sv
// Latency-modelled code/data memory. A request held on select completes after
// LATENCY edges with exactly one read or write; out-of-range (or protected)
// accesses complete with access_err. Optional macro SPELL_MEM_CODE_WP_EN adds
// a code_wp input that refuses code-memory writes while it is high.
module spell_mem_param
  import spell_mem_pkg::*;
#(
  parameter int CODE_DEPTH = DEFAULT_CODE_DEPTH,
  parameter int DATA_DEPTH = DEFAULT_DATA_DEPTH,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       select,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       memory_type_data,
  input  logic       write,
`ifdef SPELL_MEM_CODE_WP_EN
  input  logic       code_wp,
`endif
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       access_err
);

  localparam logic [8:0]       CODE_LIM   = 9'(CODE_DEPTH);
  localparam logic [8:0]       DATA_LIM   = 9'(DATA_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam int               CODE_IDX_W = bank_idx_w(CODE_DEPTH);
  localparam int               DATA_IDX_W = bank_idx_w(DATA_DEPTH);

  logic [CNT_W-1:0] cnt_r;
  logic             ready_r;
  logic             err_r;
  logic             rd_hit_r;   // completed access was an in-range read
  logic             rd_sel_r;   // which bank that read came from

  logic       access_s;
  logic       in_range_s;
  logic       wp_block_s;
  logic       refused_s;
  logic       code_we_s;
  logic       data_we_s;
  logic       code_re_s;
  logic       data_re_s;
  logic [7:0] code_rd_s;
  logic [7:0] data_rd_s;

  // Code-write protection; tied off when the feature is not built.
  always_comb begin
    wp_block_s = 1'b0;
`ifdef SPELL_MEM_CODE_WP_EN
    if (code_wp && write && (memory_type_data == MEM_TYPE_CODE)) begin
      wp_block_s = 1'b1;
    end else begin
      wp_block_s = 1'b0;
    end
`endif
  end

  // Access-edge detection and per-bank strobes; only the access edge uses the request fields.
  always_comb begin
    access_s   = select && !ready_r && (cnt_r == CNT_ZERO);
    in_range_s = addr_in_range(addr, memory_type_data ? DATA_LIM : CODE_LIM);
    refused_s  = !in_range_s || wp_block_s;
    code_we_s  = access_s && write  && (memory_type_data == MEM_TYPE_CODE) && !refused_s;
    data_we_s  = access_s && write  && (memory_type_data == MEM_TYPE_DATA) && !refused_s;
    code_re_s  = access_s && !write && (memory_type_data == MEM_TYPE_CODE) && in_range_s;
    data_re_s  = access_s && !write && (memory_type_data == MEM_TYPE_DATA) && in_range_s;
  end

  // Request sequencing: idle reload, countdown, one access, then hold until select drops.
  always_ff @(posedge clock) begin
    if (reset || !select) begin
      cnt_r    <= CNT_LOAD;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
      rd_hit_r <= 1'b0;
      rd_sel_r <= MEM_TYPE_CODE;
    end else if (!ready_r) begin
      if (access_s) begin
        ready_r  <= 1'b1;
        err_r    <= refused_s;
        rd_hit_r <= !write && in_range_s;
        rd_sel_r <= memory_type_data;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  spell_mem_bank #(.DEPTH(CODE_DEPTH)) u_code_bank (
    .clock   (clock),
    .clear   (reset),
    .wr_en   (code_we_s),
    .rd_en   (code_re_s),
    .addr    (addr[CODE_IDX_W-1:0]),
    .wr_data (data_in),
    .rd_data (code_rd_s)
  );

  spell_mem_bank #(.DEPTH(DATA_DEPTH)) u_data_bank (
    .clock   (clock),
    .clear   (reset),
    .wr_en   (data_we_s),
    .rd_en   (data_re_s),
    .addr    (addr[DATA_IDX_W-1:0]),
    .wr_data (data_in),
    .rd_data (data_rd_s)
  );

  // Read data is only presented after an in-range read completes; zero otherwise.
  always_comb begin
    if (!rd_hit_r) begin
      data_out = 8'h00;
    end else if (rd_sel_r == MEM_TYPE_DATA) begin
      data_out = data_rd_s;
    end else begin
      data_out = code_rd_s;
    end
  end

  assign data_ready = ready_r;
  assign access_err = err_r;

endmodule

// File: tb/tb_spell_mem_param.sv
// Bench for spell_mem_param: a behavioural model (edge counting plus plain
// arrays) checked against the LATENCY=4 instance every cycle, directed
// literal checks, and hold-after-ready checks on LATENCY=1/16 instances.
`timescale 1ns/1ps
module tb_spell_mem_param;

  localparam int LAT    = 4;
  localparam int CODE_D = 32;
  localparam int DATA_D = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, select, memory_type_data, write, code_wp;
  logic [7:0] addr, data_in, data_out;
  logic       data_ready, access_err;

  logic       sel_a, sel_b, wr_x;
  logic [7:0] addr_x, din_x, dout_a, dout_b;
  logic       rdy_a, rdy_b, err_a, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  spell_mem_param #(.CODE_DEPTH(CODE_D), .DATA_DEPTH(DATA_D), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .select(select), .addr(addr), .data_in(data_in),
    .memory_type_data(memory_type_data), .write(write),
`ifdef SPELL_MEM_CODE_WP_EN
    .code_wp(code_wp),
`endif
    .data_out(data_out), .data_ready(data_ready), .access_err(access_err));

  spell_mem_param #(.LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset), .select(sel_a), .addr(addr_x), .data_in(din_x),
    .memory_type_data(1'b1), .write(wr_x),
`ifdef SPELL_MEM_CODE_WP_EN
    .code_wp(1'b0),
`endif
    .data_out(dout_a), .data_ready(rdy_a), .access_err(err_a));

  spell_mem_param #(.LATENCY(16)) dut_l16 (
    .clock(clock), .reset(reset), .select(sel_b), .addr(addr_x), .data_in(din_x),
    .memory_type_data(1'b1), .write(wr_x),
`ifdef SPELL_MEM_CODE_WP_EN
    .code_wp(1'b0),
`endif
    .data_out(dout_b), .data_ready(rdy_b), .access_err(err_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the LATENCY=4 instance ----------------
  logic [7:0] code_m [256];
  logic [7:0] data_m [256];
  logic       m_ready, m_err;
  logic [7:0] m_dout;
  int         m_edges;

  initial begin
    m_ready = 1'b0; m_err = 1'b0; m_dout = 8'h00; m_edges = 0;
    forever begin
      @(posedge clock);
      if (reset) begin
        foreach (code_m[i]) code_m[i] = 8'h00;
        foreach (data_m[i]) data_m[i] = 8'h00;
        m_ready = 1'b0; m_err = 1'b0; m_dout = 8'h00; m_edges = 0;
      end else if (!select) begin
        m_ready = 1'b0; m_err = 1'b0; m_dout = 8'h00; m_edges = 0;
      end else if (!m_ready) begin
        m_edges++;
        if (m_edges == LAT) begin
          automatic int  lim = memory_type_data ? DATA_D : CODE_D;
          automatic bit  ok  = int'(addr) < lim;
          m_ready = 1'b1;
          if (write) begin
            automatic bit refused = !ok || (!memory_type_data && code_wp);
            m_err  = refused;
            m_dout = 8'h00;
            if (!refused) begin
              if (memory_type_data) data_m[addr] = data_in;
              else                  code_m[addr] = data_in;
            end
          end else begin
            m_err  = !ok;
            m_dout = !ok ? 8'h00 : (memory_type_data ? data_m[addr] : code_m[addr]);
          end
        end
      end
    end
  end

  // Every-cycle comparison of the main instance against the model.
  initial begin
    @(posedge clock);
    forever begin
      @(posedge clock);
      #1;
      check("model_ready", data_ready, m_ready);
      check("model_err",   access_err, m_err);
      check("model_dout",  data_out,   m_dout);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_access(input logic mt, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input int hold,
                           output int edges, output logic [7:0] dout, output logic err);
    @(negedge clock);
    memory_type_data = mt; write = wr; addr = a; data_in = d; select = 1'b1;
    edges = 0;
    do begin
      @(posedge clock); #1; edges++;
    end while (!data_ready && edges < 40);
    check("ready_within_bound", data_ready, 1'b1);
    dout = data_out;
    err  = access_err;
    repeat (hold) begin
      @(negedge clock);
      addr = ~a; data_in = ~d;
      @(posedge clock); #1;
    end
    @(negedge clock);
    select = 1'b0;
    @(posedge clock); #1;
  endtask

  function automatic logic rdy_of(input int w);
    return (w == 0) ? rdy_a : rdy_b;
  endfunction

  task automatic set_sel(input int w, input logic v);
    if (w == 0) sel_a = v;
    else        sel_b = v;
  endtask

  // Hold select 10 edges past data_ready; only one access may happen.
  task automatic hold_test(input int w, input int lat);
    int edges;
    for (int pass = 0; pass < 3; pass++) begin
      @(negedge clock);
      wr_x   = (pass == 0);
      addr_x = (pass == 1) ? 8'd1 : 8'd2;
      din_x  = 8'h5A;
      set_sel(w, 1'b1);
      edges = 0;
      do begin
        @(posedge clock); #1; edges++;
      end while (!rdy_of(w) && edges < 40);
      check($sformatf("lat%0d_edges", lat), edges, lat);
      repeat (10) begin
        @(negedge clock);
        addr_x = 8'd1; din_x = 8'hC3; wr_x = 1'b1;
        @(posedge clock); #1;
        check($sformatf("lat%0d_ready_held", lat), rdy_of(w), 1'b1);
        check($sformatf("lat%0d_err", lat), (w == 0) ? err_a : err_b, 1'b0);
        if (pass != 0)
          check($sformatf("lat%0d_dout_p%0d", lat, pass), (w == 0) ? dout_a : dout_b,
                (pass == 1) ? 8'h00 : 8'h5A);
      end
      @(negedge clock);
      set_sel(w, 1'b0);
      @(posedge clock); #1;
      check($sformatf("lat%0d_ready_drop", lat), rdy_of(w), 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         e;
    logic [7:0] d;
    logic       er;

    reset = 1'b1; select = 1'b0; memory_type_data = 1'b0; write = 1'b0;
    addr = 8'h00; data_in = 8'h00; code_wp = 1'b0;
    sel_a = 1'b0; sel_b = 1'b0; wr_x = 1'b0; addr_x = 8'h00; din_x = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", data_ready, 1'b0);
    check("rst_err",   access_err, 1'b0);
    check("rst_dout",  data_out,   8'h00);
    @(negedge clock);
    reset = 1'b0;

    do_access(1'b1, 1'b1, 8'd3, 8'hA5, 0, e, d, er);
    check("wr_d3_edges", e, 4);
    check("wr_d3_err", er, 1'b0);
    do_access(1'b1, 1'b0, 8'd3, 8'h00, 2, e, d, er);
    check("rd_d3_edges", e, 4);
    check("rd_d3_dout", d, 8'hA5);
    check("rd_d3_err", er, 1'b0);

    do_access(1'b0, 1'b0, 8'd32, 8'h00, 0, e, d, er);
    check("rd_c32_dout", d, 8'h00);
    check("rd_c32_err", er, 1'b1);
    do_access(1'b1, 1'b1, 8'd8, 8'hFF, 0, e, d, er);
    check("wr_d8_err", er, 1'b1);
    do_access(1'b1, 1'b0, 8'd0, 8'h00, 0, e, d, er);
    check("rd_d0_after_d8", d, 8'h00);
    do_access(1'b1, 1'b0, 8'd255, 8'h00, 0, e, d, er);
    check("rd_d255_err", er, 1'b1);

    // Aborted write: select high for only two edges.
    @(negedge clock);
    memory_type_data = 1'b0; write = 1'b1; addr = 8'd5; data_in = 8'h11; select = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    select = 1'b0;
    @(posedge clock); #1;
    do_access(1'b0, 1'b0, 8'd5, 8'h00, 0, e, d, er);
    check("abort_c5", d, 8'h00);
    check("abort_restart_edges", e, 4);

    // Request fields change during the countdown; the access edge values win.
    @(negedge clock);
    memory_type_data = 1'b1; write = 1'b0; addr = 8'd0; select = 1'b1;
    @(negedge clock);
    addr = 8'd3;
    e = 0;
    do begin
      @(posedge clock); #1; e++;
    end while (!data_ready && e < 40);
    check("late_addr_dout", data_out, 8'hA5);
    @(negedge clock);
    select = 1'b0;
    @(posedge clock); #1;

    // Reset while a completed read is being held.
    do_access(1'b0, 1'b1, 8'd0, 8'h42, 0, e, d, er);
    @(negedge clock);
    memory_type_data = 1'b0; write = 1'b0; addr = 8'd0; select = 1'b1;
    e = 0;
    do begin
      @(posedge clock); #1; e++;
    end while (!data_ready && e < 40);
    check("rd_c0_before_rst", data_out, 8'h42);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_ready", data_ready, 1'b0);
    check("midrst_err",   access_err, 1'b0);
    check("midrst_dout",  data_out,   8'h00);
    @(negedge clock);
    reset = 1'b0; select = 1'b0;
    @(posedge clock); #1;
    do_access(1'b0, 1'b0, 8'd0, 8'h00, 0, e, d, er);
    check("rd_c0_after_rst", d, 8'h00);
    do_access(1'b1, 1'b0, 8'd3, 8'h00, 0, e, d, er);
    check("rd_d3_after_rst", d, 8'h00);

`ifdef SPELL_MEM_CODE_WP_EN
    code_wp = 1'b1;
    do_access(1'b0, 1'b1, 8'd1, 8'h7E, 0, e, d, er);
    check("wp_wr_err", er, 1'b1);
    code_wp = 1'b0;
    do_access(1'b0, 1'b0, 8'd1, 8'h00, 0, e, d, er);
    check("wp_rd_blocked", d, 8'h00);
    do_access(1'b0, 1'b1, 8'd1, 8'h7E, 0, e, d, er);
    check("wp_off_wr_err", er, 1'b0);
    do_access(1'b0, 1'b0, 8'd1, 8'h00, 0, e, d, er);
    check("wp_off_rd", d, 8'h7E);
`endif

    hold_test(0, 1);
    hold_test(1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
